// File: rtl/noc_local_ni.sv
// noc_local_ni: local-port network interface for a Phoenix mesh router.
// TX side packetises host commands into header/size/payload flits under credit
// flow control; RX side buffers router flits in a credit-managed FIFO and
// frames them back to the host with sop/eop markers.
// Optional build macro NOC_NI_STATS_EN adds saturating packet counters
// stat_tx_pkts / stat_rx_pkts.
module noc_local_ni #(
    parameter int                  TAM_FLIT = 16,
    parameter logic [TAM_FLIT-1:0] ADDRESS  = '0,
    parameter int                  RX_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [TAM_FLIT-1:0] cmd_target,
    input  logic [TAM_FLIT-1:0] cmd_size,
    input  logic                pl_valid,
    output logic                pl_ready,
    input  logic [TAM_FLIT-1:0] pl_data,
    output logic                tx,
    output logic [TAM_FLIT-1:0] data_out,
    input  logic                credit_i,
    input  logic                rx,
    input  logic [TAM_FLIT-1:0] data_in,
    output logic                credit_o,
    output logic                rcv_valid,
    input  logic                rcv_ready,
    output logic [TAM_FLIT-1:0] rcv_data,
    output logic                rcv_sop,
    output logic                rcv_eop,
    output logic                err_misroute
`ifdef NOC_NI_STATS_EN
    ,
    output logic [31:0]         stat_tx_pkts,
    output logic [31:0]         stat_rx_pkts
`endif
);

    localparam int            AW      = $clog2(RX_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(RX_DEPTH);

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_HDR  = 2'd1;
    localparam logic [1:0] T_SIZE = 2'd2;
    localparam logic [1:0] T_PAY  = 2'd3;

    localparam logic [1:0] R_HDR  = 2'd0;
    localparam logic [1:0] R_SIZE = 2'd1;
    localparam logic [1:0] R_PAY  = 2'd2;

    // ---------------- TX packetiser ----------------
    logic [1:0]          tstate_q, tstate_d;
    logic [TAM_FLIT-1:0] tgt_q, tgt_d;
    logic [TAM_FLIT-1:0] size_q, size_d;
    logic [TAM_FLIT-1:0] pay_q, pay_d;
    logic [TAM_FLIT-1:0] rem_q, rem_d;     // payload words still to be loaded
    logic                pay_vld_q, pay_vld_d;
    logic                xfer;

    assign cmd_ready = reset && (tstate_q == T_IDLE);
    assign xfer      = tx && credit_i;

    // Output flit mux: the flit stays on data_out until the router takes it.
    always_comb begin
        tx       = 1'b0;
        data_out = '0;
        case (tstate_q)
            T_HDR:   begin tx = 1'b1;      data_out = tgt_q;  end
            T_SIZE:  begin tx = 1'b1;      data_out = size_q; end
            T_PAY:   begin tx = pay_vld_q; data_out = pay_q;  end
            default: begin tx = 1'b0;      data_out = '0;     end
        endcase
    end

    // TX next state; the first payload word is fetched while the size flit
    // leaves so payload flits follow the size flit without a bubble.
    always_comb begin
        tstate_d  = tstate_q;
        tgt_d     = tgt_q;
        size_d    = size_q;
        pay_d     = pay_q;
        rem_d     = rem_q;
        pay_vld_d = pay_vld_q;
        pl_ready  = 1'b0;
        case (tstate_q)
            T_IDLE: begin
                if (cmd_valid) begin
                    tgt_d    = cmd_target;
                    size_d   = cmd_size;
                    tstate_d = T_HDR;
                end
            end
            T_HDR: begin
                if (xfer) tstate_d = T_SIZE;
            end
            T_SIZE: begin
                if (xfer) begin
                    if (size_q == '0) begin
                        tstate_d = T_IDLE;
                    end else begin
                        tstate_d  = T_PAY;
                        pl_ready  = pl_valid;
                        rem_d     = size_q;
                        pay_vld_d = 1'b0;
                        if (pl_valid) begin
                            pay_d     = pl_data;
                            pay_vld_d = 1'b1;
                            rem_d     = size_q - 1'b1;
                        end
                    end
                end
            end
            default: begin
                if ((!pay_vld_q || xfer) && rem_q != '0) begin
                    pl_ready = pl_valid;
                    if (pl_valid) begin
                        pay_d     = pl_data;
                        pay_vld_d = 1'b1;
                        rem_d     = rem_q - 1'b1;
                    end else begin
                        pay_vld_d = 1'b0;
                    end
                end else if (xfer) begin
                    pay_vld_d = 1'b0;
                    if (rem_q == '0) tstate_d = T_IDLE;
                end
            end
        endcase
    end

    // TX control registers; reset drops any packet in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tstate_q  <= T_IDLE;
            rem_q     <= '0;
            pay_vld_q <= 1'b0;
        end else begin
            tstate_q  <= tstate_d;
            rem_q     <= rem_d;
            pay_vld_q <= pay_vld_d;
        end
    end

    // TX data registers; only observed while the FSM marks them valid.
    always_ff @(posedge clock) begin
        tgt_q  <= tgt_d;
        size_q <= size_d;
        pay_q  <= pay_d;
    end

    // ---------------- RX FIFO ----------------
    logic [TAM_FLIT-1:0] mem_q [RX_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q;
    logic                wr_en, rd_en;

    // Credit comes from the registered count only: a pop frees space next cycle.
    assign credit_o  = reset && (count_q < DEPTH_C);
    assign wr_en     = rx && credit_o;
    assign rcv_valid = (count_q != '0);
    assign rd_en     = rcv_valid && rcv_ready;
    assign rcv_data  = mem_q[rd_ptr_q];

    // FIFO storage write; flits offered without credit are dropped.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_in;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at RX_DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !rd_en)      count_q <= count_q + 1'b1;
            else if (!wr_en && rd_en) count_q <= count_q - 1'b1;
        end
    end

    // ---------------- RX depacketiser ----------------
    logic [1:0]          rstate_q, rstate_d;
    logic [TAM_FLIT-1:0] pcnt_q, pcnt_d;   // payload flits left including head
    logic                err_q, err_d;

    assign rcv_sop      = rcv_valid && (rstate_q == R_HDR);
    assign rcv_eop      = rcv_valid && (((rstate_q == R_SIZE) && (rcv_data == '0)) ||
                                        ((rstate_q == R_PAY) && (pcnt_q == TAM_FLIT'(1))));
    assign err_misroute = err_q;

    // Framing tracker: advances once per popped flit.
    always_comb begin
        rstate_d = rstate_q;
        pcnt_d   = pcnt_q;
        err_d    = err_q;
        if (rd_en) begin
            case (rstate_q)
                R_HDR: begin
                    rstate_d = R_SIZE;
                    if (rcv_data != ADDRESS) err_d = 1'b1;
                end
                R_SIZE: begin
                    if (rcv_data == '0) begin
                        rstate_d = R_HDR;
                    end else begin
                        pcnt_d   = rcv_data;
                        rstate_d = R_PAY;
                    end
                end
                R_PAY: begin
                    pcnt_d = pcnt_q - 1'b1;
                    if (pcnt_q == TAM_FLIT'(1)) rstate_d = R_HDR;
                end
                default: rstate_d = R_HDR;
            endcase
        end
    end

    // Depacketiser registers; misroute flag is sticky until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rstate_q <= R_HDR;
            pcnt_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            pcnt_q   <= pcnt_d;
            err_q    <= err_d;
        end
    end

`ifdef NOC_NI_STATS_EN
    // ---------------- packet statistics ----------------
    logic        last_xfer;
    logic [31:0] stat_tx_q, stat_rx_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign last_xfer    = xfer && (((tstate_q == T_SIZE) && (size_q == '0)) ||
                                   ((tstate_q == T_PAY) && (rem_q == '0)));
    assign stat_tx_pkts = stat_tx_q;
    assign stat_rx_pkts = stat_rx_q;

    // Count completed packets in each direction, saturating at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_tx_q <= '0;
            stat_rx_q <= '0;
        end else begin
            if (last_xfer)         stat_tx_q <= sat_inc(stat_tx_q);
            if (rd_en && rcv_eop)  stat_rx_q <= sat_inc(stat_rx_q);
        end
    end
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// Directed self-checking bench for noc_local_ni (TAM_FLIT=16, ADDRESS=0x0011, RX_DEPTH=4).
module tb_noc_local_ni;
    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_target, cmd_size;
    logic        pl_valid, pl_ready;
    logic [15:0] pl_data;
    logic        tx;
    logic [15:0] data_out;
    logic        credit_i;
    logic        rx;
    logic [15:0] data_in;
    logic        credit_o;
    logic        rcv_valid, rcv_ready;
    logic [15:0] rcv_data;
    logic        rcv_sop, rcv_eop, err_misroute;
`ifdef NOC_NI_STATS_EN
    logic [31:0] stat_tx_pkts, stat_rx_pkts;
`endif

    noc_local_ni #(.TAM_FLIT(16), .ADDRESS(16'h0011), .RX_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_size(cmd_size),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .tx(tx), .data_out(data_out), .credit_i(credit_i),
        .rx(rx), .data_in(data_in), .credit_o(credit_o),
        .rcv_valid(rcv_valid), .rcv_ready(rcv_ready), .rcv_data(rcv_data),
        .rcv_sop(rcv_sop), .rcv_eop(rcv_eop), .err_misroute(err_misroute)
`ifdef NOC_NI_STATS_EN
        , .stat_tx_pkts(stat_tx_pkts), .stat_rx_pkts(stat_rx_pkts)
`endif
    );

    always #5 clock = ~clock;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] pay      [0:7];
    logic [15:0] got      [0:15];
    int          got_cyc  [0:15];
    logic        tx_log   [0:63];
    logic [15:0] dout_log [0:63];
    logic [15:0] exp_seq  [0:7];
    int          nfl;

    task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_chk++;
        if (got_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one command and act as host payload source; logs each cycle and
    // every accepted flit. Stops after 'limit' transfers or a cycle budget.
    task automatic run_tx(input logic [15:0] tgt, input logic [15:0] sz,
                          input int stall_at, input int stall_len,
                          input int limit, output int nf);
        int   cyc;
        int   pidx;
        logic cons;
        cmd_target = tgt;
        cmd_size   = sz;
        cmd_valid  = 1'b1;
        #1;
        check_eq("cmd_ready_before_cmd", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        pidx      = 0;
        pl_valid  = 1'b1;
        pl_data   = pay[0];
        nf        = 0;
        cyc       = 0;
        while (nf < limit && cyc < 60) begin
            credit_i = (cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b0 : 1'b1;
            #1;
            tx_log[cyc]   = tx;
            dout_log[cyc] = data_out;
            if (tx && credit_i) begin
                got[nf]     = data_out;
                got_cyc[nf] = cyc;
                nf++;
            end
            cons = pl_valid && pl_ready;
            tick();
            cyc++;
            if (cons && pidx < 7) begin
                pidx++;
                pl_data = pay[pidx];
            end
        end
        pl_valid = 1'b0;
        credit_i = 1'b1;
    endtask

    task automatic push(input logic [15:0] d);
        rx      = 1'b1;
        data_in = d;
        tick();
        rx      = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 0; cmd_target = 0; cmd_size = 0;
        pl_valid = 0; pl_data = 0; credit_i = 1;
        rx = 0; data_in = 0; rcv_ready = 0;
        for (int i = 0; i < 8; i++) pay[i] = 16'h0;
        #2 reset = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_tx", tx, 0);
        check_eq("rst_data_out", data_out, 0);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_pl_ready", pl_ready, 0);
        check_eq("rst_credit_o", credit_o, 0);
        check_eq("rst_rcv_valid", rcv_valid, 0);
        check_eq("rst_rcv_sop", rcv_sop, 0);
        check_eq("rst_rcv_eop", rcv_eop, 0);
        check_eq("rst_err", err_misroute, 0);
        reset = 1'b1;
        tick();
        check_eq("post_rst_cmd_ready", cmd_ready, 1);
        check_eq("post_rst_credit_o", credit_o, 1);

        // TX: full-rate packet, 5 flits on consecutive cycles
        pay[0] = 16'h00A1; pay[1] = 16'h00A2; pay[2] = 16'h00A3;
        exp_seq[0] = 16'h0102; exp_seq[1] = 16'h0003;
        exp_seq[2] = 16'h00A1; exp_seq[3] = 16'h00A2; exp_seq[4] = 16'h00A3;
        run_tx(16'h0102, 16'd3, 100, 0, 5, nfl);
        check_eq("t1_nflits", nfl, 5);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t1_flit%0d", i), got[i], exp_seq[i]);
            check_eq($sformatf("t1_cyc%0d", i), got_cyc[i], i);
        end
        check_eq("t1_cmd_ready_after", cmd_ready, 1);
        check_eq("t1_tx_idle", tx, 0);

        // TX: credit withheld 4 cycles during the size flit
        run_tx(16'h0102, 16'd3, 1, 4, 5, nfl);
        check_eq("t2_nflits", nfl, 5);
        for (int c = 1; c < 5; c++) begin
            check_eq($sformatf("t2_stall_tx%0d", c), tx_log[c], 1);
            check_eq($sformatf("t2_stall_dout%0d", c), dout_log[c], 16'h0003);
        end
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("t2_flit%0d", i), got[i], exp_seq[i]);
        check_eq("t2_size_cyc", got_cyc[1], 5);

        // RX: well-formed packet streamed straight through
        rcv_ready = 1'b1;
        exp_seq[0] = 16'h0011; exp_seq[1] = 16'h0002;
        exp_seq[2] = 16'h00B1; exp_seq[3] = 16'h00B2;
        for (int i = 0; i < 4; i++) begin
            push(exp_seq[i]);
            check_eq($sformatf("t3_valid%0d", i), rcv_valid, 1);
            check_eq($sformatf("t3_data%0d", i), rcv_data, exp_seq[i]);
            check_eq($sformatf("t3_sop%0d", i), rcv_sop, (i == 0) ? 1 : 0);
            check_eq($sformatf("t3_eop%0d", i), rcv_eop, (i == 3) ? 1 : 0);
        end
        tick();
        check_eq("t3_empty", rcv_valid, 0);
        check_eq("t3_err", err_misroute, 0);

        // RX: fill FIFO, check credit, overflow ignored, single pop frees credit
        rcv_ready = 1'b0;
        exp_seq[0] = 16'h0011; exp_seq[1] = 16'h0002;
        exp_seq[2] = 16'h00C1; exp_seq[3] = 16'h00C2;
        for (int i = 0; i < 4; i++) begin
            push(exp_seq[i]);
            check_eq($sformatf("t4_credit%0d", i), credit_o, (i < 3) ? 1 : 0);
        end
        push(16'h00C9);
        check_eq("t4_credit_full", credit_o, 0);
        check_eq("t4_head", rcv_data, 16'h0011);
        check_eq("t4_head_sop", rcv_sop, 1);
        rcv_ready = 1'b1;
        tick();
        rcv_ready = 1'b0;
        check_eq("t4_credit_after_pop", credit_o, 1);
        rcv_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            check_eq($sformatf("t4_drain%0d", i), rcv_data, exp_seq[i]);
            check_eq($sformatf("t4_eop%0d", i), rcv_eop, (i == 3) ? 1 : 0);
            tick();
        end
        check_eq("t4_overflow_dropped", rcv_valid, 0);

        // RX: misrouted zero-size packet, then a valid one; flag stays set
        push(16'h0022);
        check_eq("t5_hdr_sop", rcv_sop, 1);
        push(16'h0000);
        check_eq("t5_size0_eop", rcv_eop, 1);
        check_eq("t5_err_set", err_misroute, 1);
        push(16'h0011);
        check_eq("t5_hdr2_sop", rcv_sop, 1);
        push(16'h0001);
        check_eq("t5_size1_eop", rcv_eop, 0);
        push(16'h00D1);
        check_eq("t5_pay_eop", rcv_eop, 1);
        tick();
        check_eq("t5_err_sticky", err_misroute, 1);
        rcv_ready = 1'b0;

        // TX: reset after 2 of 5 payload flits, then a clean packet
        pay[0] = 16'h00E1; pay[1] = 16'h00E2; pay[2] = 16'h00E3;
        pay[3] = 16'h00E4; pay[4] = 16'h00E5;
        run_tx(16'h0102, 16'd5, 100, 0, 4, nfl);
        check_eq("t6_nflits_pre", nfl, 4);
        check_eq("t6_last_pre", got[3], 16'h00E2);
        check_eq("t6_tx_busy", tx, 1);
        reset = 1'b0;
        #1;
        check_eq("t6_rst_tx", tx, 0);
        check_eq("t6_rst_dout", data_out, 0);
        check_eq("t6_rst_cmd_ready", cmd_ready, 0);
        check_eq("t6_rst_credit_o", credit_o, 0);
        check_eq("t6_rst_err", err_misroute, 0);
        tick();
        reset = 1'b1;
        tick();
        check_eq("t6_idle_cmd_ready", cmd_ready, 1);
        check_eq("t6_idle_tx", tx, 0);
        pay[0] = 16'h00F1; pay[1] = 16'h00F2;
        exp_seq[0] = 16'h0304; exp_seq[1] = 16'h0002;
        exp_seq[2] = 16'h00F1; exp_seq[3] = 16'h00F2;
        run_tx(16'h0304, 16'd2, 100, 0, 4, nfl);
        check_eq("t6_nflits_post", nfl, 4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t6_flit%0d", i), got[i], exp_seq[i]);
        check_eq("t6_first_cyc", got_cyc[0], 0);
        check_eq("t6_cmd_ready_end", cmd_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
